// File: rtl/interfaz_pspl_mc.sv
// PS/PL command interface: decodes PS opcodes from ctrl_in, runs a
// sync/ack handshake with the selected PL channel (CALC), moves PS data
// words into a per-channel input buffer (SCAN) and returns words of a
// per-channel output buffer to PS (PRINT).
// Ports:
//   clock, reset          rising-edge clock, async active-high reset
//   ctrl_in  [7:0]        PS command: [3:0] opcode, [7:4] channel
//   ctrl_out [7:0]        status to PS: [3:0] status code, [7:4] channel
//   data_in / data_out    PS data words (DATA_WIDTH)
//   sync / ack            per-channel PL request / acknowledge
//   buffer_in             N_CH slices of BUFFER_IN_WIDTH, written by SCAN
//   buffer_out            N_CH slices of BUFFER_OUT_WIDTH, read by PRINT
module interfaz_pspl_mc #(
  parameter int DATA_WIDTH       = 32,
  parameter int BUFFER_IN_WIDTH  = 16,
  parameter int BUFFER_OUT_WIDTH = 16,
  parameter int N_CH             = 4,
  parameter int TIMEOUT          = 1024
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic [7:0]                         ctrl_in,
  output logic [7:0]                         ctrl_out,
  input  logic [DATA_WIDTH-1:0]              data_in,
  output logic [DATA_WIDTH-1:0]              data_out,
  output logic [N_CH-1:0]                    sync,
  input  logic [N_CH-1:0]                    ack,
  output logic [N_CH*BUFFER_IN_WIDTH-1:0]    buffer_in,
  input  logic [N_CH*BUFFER_OUT_WIDTH-1:0]   buffer_out
);

  localparam logic [3:0] OP_IDLE       = 4'd0;
  localparam logic [3:0] OP_CALC       = 4'd1;
  localparam logic [3:0] OP_SCAN       = 4'd2;
  localparam logic [3:0] OP_PRINT      = 4'd3;
  localparam logic [3:0] OP_IDLE_SYNC  = 4'd5;
  localparam logic [3:0] OP_CALC_SYNC  = 4'd6;
  localparam logic [3:0] OP_SCAN_SYNC  = 4'd7;
  localparam logic [3:0] OP_PRINT_SYNC = 4'd8;
  localparam logic [3:0] OP_ERROR      = 4'd9;

  localparam int unsigned NW_IN  = (BUFFER_IN_WIDTH + DATA_WIDTH - 1) / DATA_WIDTH;
  localparam int unsigned NW_OUT = (BUFFER_OUT_WIDTH + DATA_WIDTH - 1) / DATA_WIDTH;
  localparam int unsigned NW_MAX = (NW_IN > NW_OUT) ? NW_IN : NW_OUT;
  localparam int unsigned KW     = $clog2(NW_MAX + 1);
  localparam int unsigned TW     = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  localparam logic [KW-1:0] LAST_IN  = KW'(NW_IN - 1);
  localparam logic [KW-1:0] LAST_OUT = KW'(NW_OUT - 1);
  localparam logic [TW-1:0] TMO_LAST = (TIMEOUT > 0) ? TW'(TIMEOUT - 1) : '0;
  localparam logic [4:0]    NCH5     = 5'(N_CH);

  typedef enum logic [3:0] {
    S_IDLE, S_CALC_REQ, S_CALC_REL, S_CALC_SYNC,
    S_SCAN, S_SCAN_SYNC, S_PRINT, S_PRINT_SYNC, S_ERROR
  } state_t;

  state_t                 state;
  logic [7:0]             ctrl_q;
  logic [DATA_WIDTH-1:0]  data_q;
  logic [N_CH-1:0]        ack_q;
  logic [3:0]             ch;
  logic [KW-1:0]          k;
  logic [TW-1:0]          tmo;

  logic [3:0]             cmd_op, cmd_ch, sel_ch;
  logic                   cmd_ch_ok, ack_hit;
  logic [N_CH-1:0]        ch_mask;
  logic [KW-1:0]          sel_k;
  logic [DATA_WIDTH-1:0]  out_word;

  assign cmd_op    = ctrl_q[3:0];
  assign cmd_ch    = ctrl_q[7:4];
  assign cmd_ch_ok = ({1'b0, cmd_ch} < NCH5);
  assign ch_mask   = N_CH'(1) << ch;
  assign ack_hit   = |(ack_q & ch_mask);

  // Word the next PRINT cycle will present: from IDLE it is word 0 of the
  // channel being commanded, from PRINT_SYNC it is the following word.
  assign sel_ch = (state == S_IDLE) ? cmd_ch : ch;
  assign sel_k  = (state == S_PRINT_SYNC) ? k + 1'b1 : k;

  always_comb begin
    out_word = '0;
    for (int unsigned c = 0; c < N_CH; c++)
      for (int unsigned b = 0; b < BUFFER_OUT_WIDTH; b++)
        if (sel_ch == 4'(c) && sel_k == KW'(b / DATA_WIDTH))
          out_word[b % DATA_WIDTH] = buffer_out[c*BUFFER_OUT_WIDTH + b];
  end

  if (BUFFER_IN_WIDTH < DATA_WIDTH) begin : g_dq_spare
    logic unused_dq_hi;
    assign unused_dq_hi = ^data_q[DATA_WIDTH-1:BUFFER_IN_WIDTH];
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      ctrl_q    <= '0;
      data_q    <= '0;
      ack_q     <= '0;
      ch        <= '0;
      k         <= '0;
      tmo       <= '0;
      sync      <= '0;
      data_out  <= '0;
      buffer_in <= '0;
      ctrl_out  <= {4'h0, OP_IDLE_SYNC};
    end else begin
      ctrl_q <= ctrl_in;
      data_q <= data_in;
      ack_q  <= ack;
      case (state)
        S_IDLE: begin
          k   <= '0;
          tmo <= '0;
          if (cmd_op == OP_CALC || cmd_op == OP_SCAN || cmd_op == OP_PRINT) begin
            ch <= cmd_ch;
            if (!cmd_ch_ok) begin
              state    <= S_ERROR;
              ctrl_out <= {cmd_ch, OP_ERROR};
            end else begin
              case (cmd_op)
                OP_CALC: begin
                  state    <= S_CALC_REQ;
                  sync     <= N_CH'(1) << cmd_ch;
                  ctrl_out <= {cmd_ch, OP_CALC};
                end
                OP_SCAN: begin
                  state    <= S_SCAN;
                  ctrl_out <= {cmd_ch, OP_SCAN};
                end
                default: begin
                  state    <= S_PRINT;
                  data_out <= out_word;
                  ctrl_out <= {cmd_ch, OP_PRINT};
                end
              endcase
            end
          end
        end
        S_CALC_REQ, S_CALC_REL: begin
          // Request phase waits for ack high, release phase for ack low;
          // both share the timeout counter.
          if ((state == S_CALC_REQ) ? ack_hit : !ack_hit) begin
            tmo  <= '0;
            sync <= '0;
            if (state == S_CALC_REQ) begin
              state <= S_CALC_REL;
            end else begin
              state    <= S_CALC_SYNC;
              ctrl_out <= {ch, OP_CALC_SYNC};
            end
          end else if (TIMEOUT > 0) begin
            if (tmo == TMO_LAST) begin
              state    <= S_ERROR;
              tmo      <= '0;
              sync     <= '0;
              ctrl_out <= {ch, OP_ERROR};
            end else begin
              tmo <= tmo + 1'b1;
            end
          end
        end
        S_CALC_SYNC, S_ERROR: begin
          if (cmd_op == OP_IDLE) begin
            state    <= S_IDLE;
            k        <= '0;
            ctrl_out <= {4'h0, OP_IDLE_SYNC};
          end
        end
        S_SCAN: begin
          if (cmd_op == OP_SCAN_SYNC) begin
            for (int unsigned c = 0; c < N_CH; c++)
              for (int unsigned b = 0; b < BUFFER_IN_WIDTH; b++)
                if (ch == 4'(c) && k == KW'(b / DATA_WIDTH))
                  buffer_in[c*BUFFER_IN_WIDTH + b] <= data_q[b % DATA_WIDTH];
            state    <= S_SCAN_SYNC;
            ctrl_out <= {ch, OP_SCAN_SYNC};
          end
        end
        S_SCAN_SYNC: begin
          if (cmd_op == OP_SCAN) begin
            if (k == LAST_IN) begin
              state    <= S_ERROR;
              ctrl_out <= {ch, OP_ERROR};
            end else begin
              k        <= k + 1'b1;
              state    <= S_SCAN;
              ctrl_out <= {ch, OP_SCAN};
            end
          end else if (cmd_op == OP_IDLE) begin
            state    <= S_IDLE;
            k        <= '0;
            ctrl_out <= {4'h0, OP_IDLE_SYNC};
          end
        end
        S_PRINT: begin
          data_out <= out_word;
          if (cmd_op == OP_PRINT_SYNC) begin
            state    <= S_PRINT_SYNC;
            ctrl_out <= {ch, OP_PRINT_SYNC};
          end
        end
        S_PRINT_SYNC: begin
          if (cmd_op == OP_PRINT) begin
            if (k == LAST_OUT) begin
              state    <= S_ERROR;
              ctrl_out <= {ch, OP_ERROR};
            end else begin
              k        <= k + 1'b1;
              state    <= S_PRINT;
              data_out <= out_word;
              ctrl_out <= {ch, OP_PRINT};
            end
          end else if (cmd_op == OP_IDLE) begin
            state    <= S_IDLE;
            k        <= '0;
            ctrl_out <= {4'h0, OP_IDLE_SYNC};
          end
        end
        default: begin
          state    <= S_IDLE;
          sync     <= '0;
          ctrl_out <= {4'h0, OP_IDLE_SYNC};
        end
      endcase
    end
  end

endmodule

// File: tb/tb_interfaz_pspl_mc.sv
// Self-checking bench for interfaz_pspl_mc: directed scenarios plus
// randomized scan/print/calc transactions checked against a reference model.
module tb_interfaz_pspl_mc;

  localparam int DW  = 32;
  localparam int BIW = 48;
  localparam int BOW = 16;
  localparam int NCH = 4;
  localparam int TMO = 8;

  logic                 clock = 1'b0;
  logic                 reset;
  logic [7:0]           ctrl_in;
  logic [7:0]           ctrl_out;
  logic [DW-1:0]        data_in;
  logic [DW-1:0]        data_out;
  logic [NCH-1:0]       sync;
  logic [NCH-1:0]       ack;
  logic [NCH*BIW-1:0]   buffer_in;
  logic [NCH*BOW-1:0]   buffer_out;

  interfaz_pspl_mc #(
    .DATA_WIDTH(DW), .BUFFER_IN_WIDTH(BIW), .BUFFER_OUT_WIDTH(BOW),
    .N_CH(NCH), .TIMEOUT(TMO)
  ) dut (
    .clock(clock), .reset(reset), .ctrl_in(ctrl_in), .ctrl_out(ctrl_out),
    .data_in(data_in), .data_out(data_out), .sync(sync), .ack(ack),
    .buffer_in(buffer_in), .buffer_out(buffer_out)
  );

  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;

  logic [BIW-1:0] mdl_buf [NCH];
  logic [BOW-1:0] bo_val  [NCH];

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] st(input int ch, input logic [3:0] code);
    return {ch[3:0], code};
  endfunction

  task automatic cmd(input logic [3:0] op, input int ch);
    ctrl_in = {ch[3:0], op};
    step(2);
  endtask

  task automatic apply_bo();
    for (int c = 0; c < NCH; c++) buffer_out[c*BOW +: BOW] = bo_val[c];
  endtask

  task automatic chk_bufs(input string tag);
    for (int c = 0; c < NCH; c++)
      chk($sformatf("%s_bufin_ch%0d", tag, c), 64'(buffer_in[c*BIW +: BIW]), 64'(mdl_buf[c]));
  endtask

  task automatic do_scan(input int ch, input int nw, input logic [31:0] w0, input logic [31:0] w1);
    cmd(4'd2, ch);
    chk("scan_enter", ctrl_out, st(ch, 4'd2));
    data_in = w0;
    cmd(4'd7, ch);
    chk("scan_sync_w0", ctrl_out, st(ch, 4'd7));
    mdl_buf[ch][31:0] = w0;
    if (nw == 2) begin
      cmd(4'd2, ch);
      chk("scan_next_word", ctrl_out, st(ch, 4'd2));
      data_in = w1;
      cmd(4'd7, ch);
      chk("scan_sync_w1", ctrl_out, st(ch, 4'd7));
      mdl_buf[ch][47:32] = w1[15:0];
      cmd(4'd2, ch);
      chk("scan_overrun_err", ctrl_out, st(ch, 4'd9));
    end
    chk_bufs("scan");
    cmd(4'd0, ch);
    chk("scan_back_idle", ctrl_out, 8'h05);
  endtask

  task automatic do_print(input int ch);
    logic [BOW-1:0] held;
    apply_bo();
    cmd(4'd3, ch);
    chk("print_enter", ctrl_out, st(ch, 4'd3));
    chk("print_data", data_out, 64'(bo_val[ch]));
    cmd(4'd8, ch);
    chk("print_sync", ctrl_out, st(ch, 4'd8));
    held = bo_val[ch];
    for (int c = 0; c < NCH; c++) bo_val[c] = BOW'($urandom);
    apply_bo();
    step(2);
    chk("print_sync_hold", data_out, 64'(held));
    cmd(4'd3, ch);
    chk("print_overrun_err", ctrl_out, st(ch, 4'd9));
    cmd(4'd0, ch);
    chk("print_back_idle", ctrl_out, 8'h05);
  endtask

  task automatic do_calc(input int ch, input int d_up, input int d_dn);
    logic [NCH-1:0] hot;
    hot = NCH'(1) << ch;
    ctrl_in = {ch[3:0], 4'd1};
    for (int i = 0; i < 20 && sync !== hot; i++) step(1);
    chk("calc_sync_high", sync, hot);
    step(d_up);
    chk("calc_sync_held", sync, hot);
    ack = hot;
    for (int i = 0; i < 20 && sync !== '0; i++) step(1);
    chk("calc_sync_low", sync, 0);
    chk("calc_rel_chan", ctrl_out[7:4], 64'(ch));
    step(d_dn);
    ack = '0;
    for (int i = 0; i < 20 && ctrl_out !== st(ch, 4'd6); i++) step(1);
    chk("calc_done", ctrl_out, st(ch, 4'd6));
    chk("calc_done_sync", sync, 0);
    cmd(4'd0, ch);
    chk("calc_back_idle", ctrl_out, 8'h05);
  endtask

  initial begin
    reset = 1'b1;
    ctrl_in = '0;
    data_in = '0;
    ack = '0;
    buffer_out = '0;
    for (int c = 0; c < NCH; c++) begin
      mdl_buf[c] = '0;
      bo_val[c]  = '0;
    end
    step(2);
    chk("rst_ctrl_out", ctrl_out, 8'h05);
    chk("rst_sync", sync, 0);
    chk("rst_data_out", data_out, 0);
    chk_bufs("rst");
    @(negedge clock);
    reset = 1'b0;
    step(2);

    // Calc handshake on channel 2: ack 3 cycles after sync, drop 2 after.
    do_calc(2, 3, 2);

    // Scan two words into channel 1 (48-bit buffer, partial second word).
    do_scan(1, 2, 32'hAAAA5555, 32'h00001234);
    chk("scan_directed_slice1", 64'(buffer_in[1*BIW +: BIW]), 64'h1234_AAAA5555);

    // Print channel 3.
    bo_val[3] = 16'hBEEF;
    do_print(3);

    // Timeout: ack never comes, ERROR after exactly TMO cycles in CALC_REQ.
    ack = '0;
    cmd(4'd1, 0);
    chk("tmo_sync_high", sync, 1);
    step(TMO - 1);
    chk("tmo_not_early", sync, 1);
    step(1);
    chk("tmo_sync_low", sync, 0);
    chk("tmo_error", ctrl_out, 8'h09);
    cmd(4'd0, 0);
    chk("tmo_back_idle", ctrl_out, 8'h05);

    // Out-of-range channel goes to ERROR, sync never asserted.
    ctrl_in = {4'd5, 4'd1};
    for (int i = 0; i < 4; i++) begin
      step(1);
      chk("oor_no_sync", sync, 0);
    end
    chk("oor_error", ctrl_out, 8'h59);
    cmd(4'd0, 0);
    chk("oor_back_idle", ctrl_out, 8'h05);

    // Randomized transactions.
    for (int it = 0; it < 8; it++) begin
      int ch;
      int kind;
      ch   = int'($urandom_range(0, NCH - 1));
      kind = int'($urandom_range(0, 2));
      if (kind == 0) begin
        do_scan(ch, int'($urandom_range(1, 2)), $urandom, $urandom);
      end else if (kind == 1) begin
        for (int c = 0; c < NCH; c++) bo_val[c] = BOW'($urandom);
        do_print(ch);
      end else begin
        do_calc(ch, int'($urandom_range(0, 4)), int'($urandom_range(0, 4)));
      end
    end
    chk_bufs("rand_end");

    // Reset mid-handshake: sync must clear without waiting for a clock.
    ctrl_in = {4'd1, 4'd1};
    step(2);
    chk("rmid_sync_high", sync, 4'b0010);
    #3;
    reset = 1'b1;
    #1;
    chk("rmid_sync_async", sync, 0);
    chk("rmid_ctrl_out", ctrl_out, 8'h05);
    chk("rmid_data_out", data_out, 0);
    for (int c = 0; c < NCH; c++) mdl_buf[c] = '0;
    chk_bufs("rmid");
    ctrl_in = '0;
    @(negedge clock);
    reset = 1'b0;
    step(3);
    chk("post_rst_idle", ctrl_out, 8'h05);
    chk("post_rst_sync", sync, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/interfaz_pspl_mc.md
INTERFAZ_PSPL_MC -- requirements
Module: interfaz_pspl_mc

Interface
REQ-001 Parameter DATA_WIDTH, default 32: width of one PS data word.
REQ-002 Parameter BUFFER_IN_WIDTH, default 16: per-channel width of the buffer written by PS.
REQ-003 Parameter BUFFER_OUT_WIDTH, default 16: per-channel width of the buffer read by PS.
REQ-004 Parameter N_CH, default 4, range 1..16: number of PL handshake channels.
REQ-005 Parameter TIMEOUT, default 1024: maximum CALC handshake wait in cycles; 0 disables the timeout.
REQ-006 clock  input  1  single clock; all logic is on its rising edge.
REQ-007 reset  input  1  asynchronous, active-high reset.
REQ-008 ctrl_in  input  8  PS command: [3:0] opcode, [7:4] channel index.
REQ-009 ctrl_out  output  8  status to PS: [3:0] status code, [7:4] active channel.
REQ-010 data_in  input  DATA_WIDTH  data word from PS.
REQ-011 data_out  output  DATA_WIDTH  data word to PS.
REQ-012 sync  output  N_CH  per-channel request to PL.
REQ-013 ack  input  N_CH  per-channel acknowledge from PL.
REQ-014 buffer_in  output  N_CH*BUFFER_IN_WIDTH  channel c occupies slice [c*BUFFER_IN_WIDTH +: BUFFER_IN_WIDTH].
REQ-015 buffer_out  input  N_CH*BUFFER_OUT_WIDTH  channel c occupies slice [c*BUFFER_OUT_WIDTH +: BUFFER_OUT_WIDTH].

Function
REQ-016 Opcodes SHALL be: idle=0, calc=1, scan=2, print=3, end=4, idle_sync=5, calc_sync=6, scan_sync=7, print_sync=8, error=9.
REQ-017 ctrl_in, data_in and ack SHALL be registered once before use, so every decision sees inputs delayed by one cycle.
REQ-018 States SHALL be IDLE, CALC_REQ, CALC_REL, CALC_SYNC, SCAN, SCAN_SYNC, PRINT, PRINT_SYNC and ERROR.
REQ-019 In IDLE: ctrl_out[3:0]=idle_sync and the word counter is cleared.
  - On calc, scan or print, the FSM latches channel ch=ctrl_in[7:4] and moves to CALC_REQ, SCAN or PRINT respectively.
  - On any other opcode the FSM stays in IDLE.
REQ-020 A calc, scan or print command with ch>=N_CH SHALL move the FSM to ERROR instead.
REQ-021 CALC_REQ: sync[ch]=1. On registered ack[ch]=1 the FSM moves to CALC_REL.
REQ-022 CALC_REL: sync[ch]=0. On registered ack[ch]=0 the FSM moves to CALC_SYNC.
REQ-023 CALC_SYNC: ctrl_out[3:0]=calc_sync. The FSM returns to IDLE on the idle opcode.
REQ-024 Only sync[ch] SHALL ever be high; all other sync bits are 0 at all times.
REQ-025 Timeout: a cycle counter runs in CALC_REQ and CALC_REL and clears on each state change. When it reaches TIMEOUT (TIMEOUT>0), sync drops to 0 and the FSM moves to ERROR.
REQ-026 Words per transfer: NW_IN=ceil(BUFFER_IN_WIDTH/DATA_WIDTH) and NW_OUT=ceil(BUFFER_OUT_WIDTH/DATA_WIDTH). Word k maps to buffer bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-027 Partial final word: the final word is truncated to the remaining bits, taken from the LSBs of data_in. On output, the unused upper bits of data_out are 0.
REQ-028 SCAN: ctrl_out[3:0]=scan. On scan_sync, word k of the registered data_in is written into channel ch of buffer_in, and the FSM moves to SCAN_SYNC.
REQ-029 SCAN_SYNC: ctrl_out[3:0]=scan_sync.
  - On scan: k increments and the FSM moves to SCAN. If k+1=NW_IN, it moves to ERROR instead.
  - On idle: the FSM moves to IDLE.
REQ-030 PRINT: ctrl_out[3:0]=print and data_out = word k of channel ch of buffer_out. On print_sync the FSM moves to PRINT_SYNC.
REQ-031 PRINT_SYNC: ctrl_out[3:0]=print_sync and data_out holds its value.
  - On print: k increments and the FSM moves to PRINT. If k+1=NW_OUT, it moves to ERROR instead.
  - On idle: the FSM moves to IDLE.
REQ-032 ERROR: ctrl_out[3:0]=error, all sync bits are 0, and buffer_in is unchanged. Only the idle opcode returns the FSM to IDLE.
REQ-033 ctrl_out[7:4] SHALL show the latched ch in every state other than IDLE, and 0 in IDLE.
REQ-034 buffer_in bits of non-selected channels, and non-addressed words, SHALL never change.

Reset
REQ-035 On reset=1, the FSM SHALL go to IDLE immediately.
  - ctrl_out is set to {4'h0, idle_sync}.
  - data_out, sync, buffer_in, ch, the word counter, the timeout counter and all input registers are set to 0.
REQ-036 Reset asserted mid-handshake SHALL drop sync the same instant. No partial SCAN word is committed.

Verification
REQ-037 N_CH=4: calc on ch=2, then PL raises ack[2] 3 cycles after sync[2] and drops it 2 cycles after sync falls.
  - Required: sync=4'b0100 then 4'b0000, then ctrl_out=8'h26.
  - Required: after idle, ctrl_out=8'h05.
REQ-038 DATA_WIDTH=32, BUFFER_IN_WIDTH=48: scan on ch=1 writing words 0xAAAA5555 then 0x00001234.
  - Required: buffer_in slice 1 = 48'h1234_AAAA5555; other slices stay 0.
REQ-039 BUFFER_OUT_WIDTH=16, channel 3 buffer_out=16'hBEEF: print on ch=3.
  - Required: data_out=32'h0000BEEF; a second print request from PRINT_SYNC gives ctrl_out[3:0]=9.
REQ-040 TIMEOUT=8, calc on ch=0 with ack held at 0.
  - Required: after 8 cycles in CALC_REQ, sync[0]=0 and ctrl_out[3:0]=9.
  - Required: idle returns the FSM to IDLE.
REQ-041 Out-of-range channel and reset mid-handshake:
  - Calc with ch=5 at N_CH=4 gives ERROR, with sync never asserted.
  - reset pulsed while sync[1]=1 clears sync asynchronously and gives ctrl_out=8'h05.
